util_cpack2_timestamp_ctrl: RTL
===============================

Name: util_cpack2_timestamp_ctrl

Overview:
ADC-domain capture scheduler placed between the channel packer and util_cpack2_timestamp. It maintains the 64-bit block timestamp and gates the packed stream into the timestamper. Each capture is armed by software, starts immediately or at a programmed timestamp, and runs for a programmed block count or continuously. It also reports capture status and sticky overflow to the register map.

Parameters:
NUM_OF_CHANNELS, 4, channels in packed word
SAMPLES_PER_CHANNEL, 1, samples per channel per word
SAMPLE_DATA_WIDTH, 16, bits per sample
(DW = NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH)

Ports:
adc_clk  in  1  sole clock
adc_rst  in  1  synchronous reset, active-high
cfg_arm  in  1  single-cycle pulse; arms a capture
cfg_abort  in  1  single-cycle pulse; ends any capture
cfg_timed  in  1  1 = start at cfg_start_time, 0 = start immediately; sampled on arm
cfg_start_time  in  64  start timestamp; sampled on arm
cfg_length  in  32  blocks to capture, 0 = continuous; sampled on arm
ts_load  in  1  load timestamp counter
ts_load_value  in  64  value loaded by ts_load
packed_fifo_wr_en  in  1  upstream block valid
packed_fifo_wr_sync  in  1  upstream sync
packed_fifo_wr_data  in  DW  upstream block
packed_fifo_wr_overflow  out  1  overflow to upstream (pass-through of gated_fifo_wr_overflow)
gated_fifo_wr_en  out  1  to timestamper packed_fifo_wr_en
gated_fifo_wr_sync  out  1  to timestamper packed_fifo_wr_sync
gated_fifo_wr_data  out  DW  to timestamper data
gated_fifo_wr_overflow  in  1  from timestamper packed_fifo_wr_overflow
timestamp  out  64  timestamp of current gated block, to timestamper timestamp
status_state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
status_overflow  out  1  sticky overflow during capture
status_count  out  32  blocks forwarded in current/last capture

Behaviour:
- Reset values: gated_fifo_wr_en, gated_fifo_wr_sync and gated_fifo_wr_data are 0. timestamp, status_count and status_overflow are 0. State is IDLE. The internal timestamp counter ts_cnt is 0.
- ts_cnt:
  - Increments by 1 on every cycle packed_fifo_wr_en=1, in all states, wrapping mod 2^64.
  - When ts_load=1, it loads ts_load_value; ts_load takes priority over increment in the same cycle.
- Forwarding pipeline, 1 cycle registered:
  - When packed_fifo_wr_en=1 and forwarding is active this cycle, next cycle gated_fifo_wr_en=1, gated data = input data, timestamp = ts_cnt before increment.
  - Otherwise gated_fifo_wr_en=0, gated_fifo_wr_data holds its previous value, gated_fifo_wr_sync=0.
  - timestamp updates only with forwarded blocks.
- Sync: gated_fifo_wr_sync=1 on the first forwarded block of a capture, OR'd with packed_fifo_wr_sync on that block. On later blocks it equals packed_fifo_wr_sync.
- FSM:
  - IDLE: on cfg_arm, latch config, clear status_count and status_overflow, go to ARMED.
  - ARMED: the start condition is true if cfg_timed=0, or if bit 63 of (ts_cnt - start_time) is 0. Comparison is wrap-safe; a past start time starts immediately. On the first cycle where the start condition holds and packed_fifo_wr_en=1, forward that block and go to CAPTURE, or to DONE if length=1.
  - CAPTURE: forward every valid block and increment status_count. On the block where status_count+1 == length (length≠0), forward it and go to DONE. length=0 never completes.
  - DONE: no forwarding. cfg_arm re-arms directly (same as from IDLE).
  - cfg_abort in any state: go to IDLE; a block valid on the abort cycle is not forwarded. Abort takes priority over arm and over the start condition in the same cycle.
  - cfg_arm while ARMED or CAPTURE is ignored.
- Overflow:
  - packed_fifo_wr_overflow = gated_fifo_wr_overflow, combinational.
  - status_overflow is set when gated_fifo_wr_overflow=1 in ARMED or CAPTURE. It is cleared only by arm or reset.
  - Overflow does not stop the capture.
- status_count saturates at 2^32-1 in continuous mode.
- adc_rst mid-capture: all state returns to reset values next cycle; no partial block is emitted.

Test Plan:
- Reset, then 10 valid blocks in IDLE -> gated_fifo_wr_en stays 0, ts_cnt=10, status_state=0.
- Immediate arm, length=4, continuous valid data D0..D9 starting with ts_cnt=10:
  - gated outputs D0..D3 with timestamp 10..13, sync=1 on D0 only.
  - status_state=3, status_count=4.
- Timed arm, start_time=100, ts_cnt=90, valid every other cycle:
  - first forwarded block has timestamp=100.
  - nothing is forwarded before it.
- Timed arm with start_time=5 while ts_cnt=50 -> starts on the next valid block, timestamp=50.
- Wrap: ts_load 0xFFFF_FFFF_FFFF_FFFE, start_time=1, 5 valid blocks:
  - ARMED across the wrap; first forwarded timestamp=1.
  - Check separately with start_time=0x...FFFF: first forwarded timestamp=0xFFFF_FFFF_FFFF_FFFF.
- Continuous capture, gated_fifo_wr_overflow pulsed once, then cfg_abort coincident with a valid block:
  - status_overflow=1 and remains 1.
  - The abort-cycle block is not forwarded; state=IDLE.
  - A re-arm clears status_overflow.

Source files
------------

// File: rtl/util_cpack2_timestamp_ctrl_if.sv
// Packed-block write stream between the channel packer, the capture
// scheduler and the timestamper. The master drives the block, the slave
// returns the overflow indication.
interface util_cpack2_timestamp_ctrl_if #(
   parameter int DW = 64
);
   logic          wr_en;
   logic          wr_sync;
   logic [DW-1:0] wr_data;
   logic          wr_overflow;

   modport master (
      output wr_en,
      output wr_sync,
      output wr_data,
      input  wr_overflow
   );

   modport slave (
      input  wr_en,
      input  wr_sync,
      input  wr_data,
      output wr_overflow
   );
endinterface

// File: rtl/util_cpack2_timestamp_ctrl.sv
// ADC-domain capture scheduler: keeps the 64-bit block timestamp, gates the
// packed stream into the timestamper for armed captures (immediate or timed,
// fixed length or continuous) and reports capture status and overflow.
module util_cpack2_timestamp_ctrl #(
   parameter  int NUM_OF_CHANNELS     = 4,
   parameter  int SAMPLES_PER_CHANNEL = 1,
   parameter  int SAMPLE_DATA_WIDTH   = 16,
   localparam int DW = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH
) (
   input  logic                         adc_clk,
   input  logic                         adc_rst,
   input  logic                         cfg_arm,
   input  logic                         cfg_abort,
   input  logic                         cfg_timed,
   input  logic [63:0]                  cfg_start_time,
   input  logic [31:0]                  cfg_length,
   input  logic                         ts_load,
   input  logic [63:0]                  ts_load_value,
   util_cpack2_timestamp_ctrl_if.slave  packed_fifo,
   util_cpack2_timestamp_ctrl_if.master gated_fifo,
   output logic [63:0]                  timestamp,
   output logic [1:0]                   status_state,
   output logic                         status_overflow,
   output logic [31:0]                  status_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [63:0] ts_cnt;
   logic        timed_q;
   logic [63:0] start_time_q;
   logic [31:0] length_q;
   logic [63:0] ts_delta;
   logic        start_ok;
   logic        last_blk;
   logic        fwd;
   logic        first_blk;
   logic        arm_take;

   // Overflow is reported straight back to the packer.
   assign packed_fifo.wr_overflow = gated_fifo.wr_overflow;
   assign status_state            = state;

   // Next-state and forwarding decision for the current cycle.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      fwd        = 1'b0;
      first_blk  = 1'b0;
      arm_take   = 1'b0;
      // Wrap-safe "ts_cnt has reached start_time": sign of the modular difference.
      ts_delta   = ts_cnt - start_time_q;
      start_ok   = !timed_q || !ts_delta[63];
      // In ARMED the count is 0, so this also covers a one-block capture.
      last_blk   = (length_q != 32'd0) && (status_count + 32'd1 == length_q);

      if (cfg_abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (cfg_arm) begin
                  arm_take   = 1'b1;
                  state_next = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (start_ok && packed_fifo.wr_en) begin
                  fwd        = 1'b1;
                  first_blk  = 1'b1;
                  state_next = last_blk ? ST_DONE : ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (packed_fifo.wr_en) begin
                  fwd = 1'b1;
                  if (last_blk) state_next = ST_DONE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Capture state register.
   always_ff @(posedge adc_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (adc_rst) state <= ST_IDLE;
      else         state <= state_next;
   end

   // Free-running block timestamp; a load wins over the increment.
   always_ff @(posedge adc_clk) begin
      if (adc_rst)                ts_cnt <= 64'd0;
      else if (ts_load)           ts_cnt <= ts_load_value;
      else if (packed_fifo.wr_en) ts_cnt <= ts_cnt + 64'd1;
   end

   // Capture configuration, latched when a capture is armed.
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         timed_q      <= 1'b0;
         start_time_q <= 64'd0;
         length_q     <= 32'd0;
      end else if (arm_take) begin
         timed_q      <= cfg_timed;
         start_time_q <= cfg_start_time;
         length_q     <= cfg_length;
      end
   end

   // Block count (saturating) and sticky overflow, both cleared on arm.
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         status_count    <= 32'd0;
         status_overflow <= 1'b0;
      end else if (arm_take) begin
         status_count    <= 32'd0;
         status_overflow <= 1'b0;
      end else begin
         if (fwd && status_count != 32'hFFFF_FFFF) status_count <= status_count + 32'd1;
         if (gated_fifo.wr_overflow && (state == ST_ARMED || state == ST_CAPTURE))
            status_overflow <= 1'b1;
      end
   end

   // One-cycle forwarding stage; data and timestamp hold between blocks.
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         gated_fifo.wr_en   <= 1'b0;
         gated_fifo.wr_sync <= 1'b0;
         gated_fifo.wr_data <= '0;
         timestamp          <= 64'd0;
      end else begin
         gated_fifo.wr_en   <= fwd;
         gated_fifo.wr_sync <= fwd && (first_blk || packed_fifo.wr_sync);
         if (fwd) begin
            gated_fifo.wr_data <= packed_fifo.wr_data;
            timestamp          <= ts_cnt;
         end
      end
   end

endmodule
